// File: rtl/dmem_responder.sv
// Data RAM responder for the memory unit: one outstanding load with a fixed
// latency and a valid/ready response, single-cycle retired-store commit, and
// squash of the in-flight load on a branch mispredict.
module dmem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LAT      = 2,
  parameter int unsigned ROB_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_func3,
  input  logic [6:0]  ld_pd,
  input  logic [4:0]  ld_rob,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_func3,
  input  logic        flush,
  input  logic [4:0]  flush_tag,
  input  logic [4:0]  rob_tail,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [6:0]  resp_pd,
  output logic [4:0]  resp_rob,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [2:0]  func3_q;
  logic [6:0]  pd_q;
  logic [4:0]  rob_q;
  logic [31:0] data_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic        accept, enter_resp, squash;
  logic [31:0] rd_addr, rd_word, fmt_data;
  logic [2:0]  rd_func3;
  logic [1:0]  off;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        fmt_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  int unsigned d_rob, d_tail;

  assign ld_req_ready = (state_q == StIdle);
  assign resp_valid   = (state_q == StResp);
  assign resp_data    = data_q;
  assign resp_err     = err_q;
  assign resp_pd      = pd_q;
  assign resp_rob     = rob_q;
  assign accept       = (state_q == StIdle) && ld_req_valid;
  assign enter_resp   = (state_d == StResp) && (state_q != StResp);

  // Squash test: distance of the load's tag from the branch tag, modulo ROB size.
  always_comb begin
    d_rob  = (32'(rob_q) % ROB_SIZE + ROB_SIZE - 32'(flush_tag) % ROB_SIZE) % ROB_SIZE;
    d_tail = (32'(rob_tail) % ROB_SIZE + ROB_SIZE - 32'(flush_tag) % ROB_SIZE) % ROB_SIZE;
    squash = flush && (state_q != StIdle) && (d_rob != 0) && (d_rob < d_tail);
  end

  // Next-state logic; a squash overrides both the countdown and the response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (ld_req_valid) begin
          if (LAT == 1) begin
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LAT - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (squash) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (squash || resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read and format; with LAT==1 the RAM is read on the accepting edge, so use live inputs.
  always_comb begin
    rd_addr  = (state_q == StIdle) ? ld_addr : addr_q;
    rd_func3 = (state_q == StIdle) ? ld_func3 : func3_q;
    rd_word  = mem[rd_addr[AW+1:2]];
    off      = rd_addr[1:0];
    rd_byte  = rd_word[{off, 3'b000} +: 8];
    rd_half  = rd_word[{off[1], 4'b0000} +: 16];
    fmt_err  = 1'b0;
    fmt_data = '0;
    case (rd_func3)
      3'b000: fmt_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001: begin
        if (off[0]) fmt_err = 1'b1;
        else fmt_data = {{16{rd_half[15]}}, rd_half};
      end
      3'b010: begin
        if (off != 2'b00) fmt_err = 1'b1;
        else fmt_data = rd_word;
      end
      3'b100: fmt_data = {24'd0, rd_byte};
      3'b101: begin
        if (off[0]) fmt_err = 1'b1;
        else fmt_data = {16'd0, rd_half};
      end
      default: fmt_err = 1'b1;
    endcase
    if (fmt_err) fmt_data = '0;
  end

  // Store byte-lane decode; misaligned or illegal stores enable no lanes.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_func3)
      3'b000: begin
        st_be    = 4'b0001 << st_addr[1:0];
        st_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        if (!st_addr[0]) st_be = st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      3'b010: begin
        if (st_addr[1:0] == 2'b00) st_be = 4'b1111;
      end
      default: st_be = 4'b0000;
    endcase
    if (!st_valid) st_be = 4'b0000;
  end

  // RAM: cleared on reset, otherwise byte-lane writes from retired stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (st_be[0]) mem[st_addr[AW+1:2]][7:0]   <= st_wdata[7:0];
      if (st_be[1]) mem[st_addr[AW+1:2]][15:8]  <= st_wdata[15:8];
      if (st_be[2]) mem[st_addr[AW+1:2]][23:16] <= st_wdata[23:16];
      if (st_be[3]) mem[st_addr[AW+1:2]][31:24] <= st_wdata[31:24];
    end
  end

  // FSM state, request capture and registered response fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      func3_q <= '0;
      pd_q    <= '0;
      rob_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= ld_addr;
        func3_q <= ld_func3;
        pd_q    <= ld_pd;
        rob_q   <= ld_rob;
      end
      if (enter_resp) begin
        data_q <= fmt_data;
        err_q  <= fmt_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// randomized store/load/flush traffic against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int ROB   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_func3 = '0;
  logic [6:0]  ld_pd = '0;
  logic [4:0]  ld_rob = '0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_func3 = '0;
  logic        flush = 1'b0;
  logic [4:0]  flush_tag = '0;
  logic [4:0]  rob_tail = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [DEPTH*4];

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT), .ROB_SIZE(ROB)) dut (
    .clk(clk), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_addr(ld_addr), .ld_func3(ld_func3), .ld_pd(ld_pd), .ld_rob(ld_rob),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_func3(st_func3),
    .flush(flush), .flush_tag(flush_tag), .rob_tail(rob_tail),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_pd(resp_pd), .resp_rob(resp_rob), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'(a[9:0]) % (DEPTH * 4);
  endfunction

  function automatic void mclear();
    for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
  endfunction

  function automatic void mstore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int b;
    b = bidx(a);
    if (f == 3'd0) begin
      mb[b] = d[7:0];
    end else if (f == 3'd1 && a[0] == 1'b0) begin
      mb[b] = d[7:0];
      mb[b+1] = d[15:8];
    end else if (f == 3'd2 && a[1:0] == 2'b00) begin
      for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
    end
  endfunction

  function automatic void mload(input logic [31:0] a, input logic [2:0] f,
                                output logic [31:0] d, output logic e);
    int b;
    logic [7:0] by;
    logic [15:0] h;
    b  = bidx(a);
    by = mb[b];
    h  = (b % 2 == 0) ? {mb[b+1], mb[b]} : 16'h0;
    e  = 1'b0;
    d  = '0;
    case (f)
      3'd0: d = {{24{by[7]}}, by};
      3'd4: d = {24'd0, by};
      3'd1: if (a[0]) e = 1'b1; else d = {{16{h[15]}}, h};
      3'd5: if (a[0]) e = 1'b1; else d = {16'd0, h};
      3'd2: if (a[1:0] != 0) e = 1'b1; else d = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      default: e = 1'b1;
    endcase
    if (e) d = '0;
  endfunction

  function automatic bit squashes(input int rob, input int tag, input int tail);
    int dr, dt;
    dr = ((rob - tag) % ROB + ROB) % ROB;
    dt = ((tail - tag) % ROB + ROB) % ROB;
    return (dr > 0) && (dr < dt);
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_func3 = f;
    @(negedge clk);
    st_valid = 1'b0;
    mstore(a, d, f);
  endtask

  // Issues one load; optionally drives a flush and/or a store in the cycle after
  // acceptance, stalls the consumer, and checks the whole response.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f, input logic [6:0] pd,
                          input logic [4:0] rob, input int stall,
                          input bit fl, input logic [4:0] ftag, input logic [4:0] ftail,
                          input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic [2:0] sf);
    logic [31:0] ed;
    logic ee;
    bit sq;
    int n, first;
    mload(a, f, ed, ee);
    sq = fl && squashes(int'(rob), int'(ftag), int'(ftail));
    @(negedge clk);
    chk("req_ready_idle", 32'(ld_req_ready), 32'd1);
    ld_req_valid = 1'b1; ld_addr = a; ld_func3 = f; ld_pd = pd; ld_rob = rob;
    @(negedge clk);
    ld_req_valid = 1'b0;
    flush = fl; flush_tag = ftag; rob_tail = ftail;
    st_valid = sv; st_addr = sa; st_data = sd; st_func3 = sf;
    first = resp_valid ? 1 : 0;
    n = 1;
    @(negedge clk);
    flush = 1'b0; st_valid = 1'b0;
    if (sv) begin
      mstore(sa, sd, sf);
      // With longer latency the store lands before the RAM is read.
      if (LAT > 2) mload(a, f, ed, ee);
    end
    n = 2;
    if (sq) begin
      chk("squash_no_valid", 32'(resp_valid), 32'd0);
      chk("squash_ready", 32'(ld_req_ready), 32'd1);
      @(negedge clk);
      chk("squash_stays_off", 32'(resp_valid), 32'd0);
      return;
    end
    while (first == 0 && n < 20) begin
      if (resp_valid) first = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("latency", 32'(first), 32'(LAT));
    if (first == 0) return;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, ed);
      chk("stall_no_ready", 32'(ld_req_ready), 32'd0);
      @(negedge clk);
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_data", resp_data, ed);
    chk("resp_err", 32'(resp_err), 32'(ee));
    chk("resp_pd", 32'(resp_pd), 32'(pd));
    chk("resp_rob", 32'(resp_rob), 32'(rob));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("taken_valid_low", 32'(resp_valid), 32'd0);
    chk("taken_ready_high", 32'(ld_req_ready), 32'd1);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f, input int stall);
    run_load(a, f, 7'($urandom), 5'($urandom_range(0, ROB - 1)), stall,
             1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  initial begin
    logic [31:0] ra, la, sd;
    mclear();
    // Reset and its outputs.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(ld_req_ready), 32'd1);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_pd", 32'(resp_pd), 32'd0);
    chk("rst_rob", 32'(resp_rob), 32'd0);

    // Word store then load.
    do_store(32'h10, 32'hDEADBEEF, 3'd2);
    ld(32'h10, 3'd2, 0);

    // Byte store, sign/zero extension, neighbouring half.
    do_store(32'h21, 32'h00000080, 3'd0);
    ld(32'h21, 3'd0, 0);
    ld(32'h21, 3'd4, 0);
    ld(32'h22, 3'd1, 0);

    // Consumer backpressure.
    ld(32'h10, 3'd2, 5);

    // Flush cases, including tag wrap.
    run_load(32'h10, 3'd2, 7'd11, 5'd7, 0, 1'b1, 5'd5, 5'd9, 1'b0, 32'd0, 32'd0, 3'd0);
    run_load(32'h10, 3'd2, 7'd12, 5'd3, 0, 1'b1, 5'd5, 5'd9, 1'b0, 32'd0, 32'd0, 3'd0);
    run_load(32'h10, 3'd2, 7'd13, 5'd0, 0, 1'b1, 5'd14, 5'd2, 1'b0, 32'd0, 32'd0, 3'd0);

    // Misaligned loads and a misaligned store that must not write.
    ld(32'h13, 3'd2, 0);
    ld(32'h15, 3'd1, 0);
    do_store(32'h13, 32'h12345678, 3'd2);
    ld(32'h10, 3'd2, 0);

    // Store on the edge the load enters RESP returns old data; next load sees it.
    run_load(32'h40, 3'd2, 7'd5, 5'd1, 0, 1'b0, 5'd0, 5'd0,
             1'b1, 32'h40, 32'hCAFEF00D, 3'd2);
    ld(32'h40, 3'd2, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      ra = $urandom; ra[9:7] = 3'b000;
      do_store(ra, $urandom, 3'($urandom_range(0, 3)));
      la = $urandom; la[9:7] = 3'b000;
      sd = $urandom;
      run_load(la, 3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom_range(0, ROB - 1)),
               $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
               5'($urandom_range(0, ROB - 1)), 5'($urandom_range(0, ROB - 1)),
               1'($urandom_range(0, 1)), {22'($urandom), 3'b000, 7'($urandom)}, sd,
               3'($urandom_range(0, 3)));
    end

    // Reset while BUSY: no response, outputs cleared, RAM cleared.
    @(negedge clk);
    ld_req_valid = 1'b1; ld_addr = 32'h10; ld_func3 = 3'd2; ld_pd = 7'd9; ld_rob = 5'd4;
    @(negedge clk);
    ld_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mclear();
    chk("busy_rst_valid", 32'(resp_valid), 32'd0);
    chk("busy_rst_ready", 32'(ld_req_ready), 32'd1);
    chk("busy_rst_pd", 32'(resp_pd), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("busy_rst_quiet", 32'(resp_valid), 32'd0);
    end
    ld(32'h10, 3'd2, 0);
    ld(32'h40, 3'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
